// File: rtl/pipe_stage_pkg.sv
// Shared types for the pipeline-register slice.
//   pipe_state_t : occupancy of a pipe_stage (EMPTY / ONE / TWO entries).
//   if_id_t, id_ex_t, ex_mem_t, mem_wb_t : stage-boundary payloads.
//   *_W localparams : payload widths, passed as DATA_W when instantiating
//                     pipe_stage at each boundary.
package pipe_stage_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  reg_rd_id;  // same width as rd so the two compare directly
    logic [3:0]  alu_op;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] rs2_val;
    logic [4:0]  reg_rd_id;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] wb_data;
    logic [4:0]  reg_rd_id;
    logic        reg_wr;
  } mem_wb_t;

  localparam int IF_ID_W  = $bits(if_id_t);
  localparam int ID_EX_W  = $bits(id_ex_t);
  localparam int EX_MEM_W = $bits(ex_mem_t);
  localparam int MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/pipe_stage_sat_counter.sv
// sat_counter: saturating up-counter for pipeline statistics.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, clears the count
//   inc   : count one event this cycle
//   count : current value, sticks at all-ones
module sat_counter
  import pipe_stage_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipe_stage.sv
// pipe_stage: valid/ready pipeline register with a 2-entry skid buffer and
// synchronous flush. in_ready, out_valid and out_data all come straight from
// flops, so no combinational path crosses the stage.
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   flush               : drop every held and incoming entry this cycle
//   in_valid/in_ready   : upstream handshake, in_data payload
//   out_valid/out_ready : downstream handshake, out_data payload
//   stall_cnt/bubble_cnt: saturating statistics, present only when the
//                         macro PIPE_STAGE_STATS_EN is defined
module pipe_stage
  import pipe_stage_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int CLEAR_ON_FLUSH = 1,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  if (DATA_W < 1 || CNT_W < 1) begin : g_bad_param
    $error("pipe_stage: DATA_W and CNT_W must be at least 1");
  end

  pipe_state_t       state_reg, state_next;
  logic [DATA_W-1:0] main_d_reg, main_d_next;
  logic [DATA_W-1:0] skid_d_reg, skid_d_next;
  logic              out_valid_reg;
  logic              in_ready_reg;
  logic              in_fire;
  logic              out_fire;

  always_comb begin
    in_fire     = in_valid & in_ready_reg;
    out_fire    = out_valid_reg & out_ready;
    state_next  = state_reg;
    main_d_next = main_d_reg;
    skid_d_next = skid_d_reg;

    case (state_reg)
      EMPTY: begin
        if (in_fire) begin
          state_next  = ONE;
          main_d_next = in_data;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d_next = in_data;
        end else if (in_fire) begin
          // Downstream stalled: park the new beat behind main.
          state_next  = TWO;
          skid_d_next = in_data;
        end else if (out_fire) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only the drain side can move.
        if (out_fire) begin
          state_next  = ONE;
          main_d_next = skid_d_reg;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase

    // Flush overrides every handshake outcome; an in_fire this cycle is
    // accepted upstream but silently dropped.
    if (flush) begin
      state_next  = EMPTY;
      main_d_next = main_d_reg;
      skid_d_next = skid_d_reg;
      if (CLEAR_ON_FLUSH != 0) begin
        main_d_next = '0;
        skid_d_next = '0;
      end
    end
  end

  // The handshake flags are registered from the next state rather than
  // decoded from state_reg, keeping them pure flop outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= EMPTY;
      main_d_reg    <= '0;
      skid_d_reg    <= '0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
    end else begin
      state_reg     <= state_next;
      main_d_reg    <= main_d_next;
      skid_d_reg    <= skid_d_next;
      out_valid_reg <= (state_next != EMPTY);
      in_ready_reg  <= (state_next != TWO);
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = main_d_reg;
  assign in_ready  = in_ready_reg;

`ifdef PIPE_STAGE_STATS_EN
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid_reg & ~out_ready),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~out_valid_reg & ~rst),
    .count (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage.sv
// Testbench for pipe_stage. Three instances share one handshake stream:
// 32-bit (clearing flush), 107-bit (non-clearing flush) and 1-bit payloads.
// A FIFO-of-depth-2 model predicts every output each cycle.
module tb_pipe_stage;
  import pipe_stage_pkg::*;

  localparam int W  = 32;
  localparam int WW = 107;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [W-1:0]  in_data;
  logic          in_ready, out_valid;
  logic [W-1:0]  out_data;
  logic [WW-1:0] in_data_w, out_data_w;
  logic          in_ready_w, out_valid_w;
  logic          in_data_n, out_data_n, in_ready_n, out_valid_n;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Behavioural model state.
  logic [W-1:0] q[$];
  logic [W-1:0] shown;
  bit           last_in_fire;
  int           m_stall, m_bubble;

  function automatic logic [WW-1:0] widen(input logic [W-1:0] d);
    return {d, d, d, d[10:0]};
  endfunction

  assign in_data_w = widen(in_data);
  assign in_data_n = in_data[0];

  always #5 clk = ~clk;

`ifdef PIPE_STAGE_STATS_EN
  logic [CW-1:0] stall_cnt, bubble_cnt, stall_w, bubble_w, stall_n, bubble_n;
`endif

  pipe_stage #(.DATA_W(W), .CLEAR_ON_FLUSH(1), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PIPE_STAGE_STATS_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  pipe_stage #(.DATA_W(WW), .CLEAR_ON_FLUSH(0), .CNT_W(CW)) dut_w (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data_w),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w)
`ifdef PIPE_STAGE_STATS_EN
    , .stall_cnt(stall_w), .bubble_cnt(bubble_w)
`endif
  );

  pipe_stage #(.DATA_W(1), .CLEAR_ON_FLUSH(1), .CNT_W(CW)) dut_n (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_n), .in_data(in_data_n),
    .out_valid(out_valid_n), .out_ready(out_ready), .out_data(out_data_n)
`ifdef PIPE_STAGE_STATS_EN
    , .stall_cnt(stall_n), .bubble_cnt(bubble_n)
`endif
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT sampled.
  task automatic model_update();
    bit mv, mr, inf, outf;
    mv   = (q.size() > 0);
    mr   = (q.size() < 2);
    inf  = in_valid && mr && !rst;
    outf = mv && out_ready && !rst;
    last_in_fire = inf;
    if (rst) begin
      m_stall  = 0;
      m_bubble = 0;
    end else begin
      if (mv && !out_ready && m_stall < 3) m_stall++;
      if (!mv && m_bubble < 3) m_bubble++;
    end
    if (rst || flush) begin
      q.delete();
      shown = '0;
    end else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back(in_data);
    end
    if (q.size() > 0) shown = q[0];
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", {127'd0, out_valid}, {127'd0, q.size() > 0});
      chk("in_ready", {127'd0, in_ready}, {127'd0, q.size() < 2});
      chk("out_data", {96'd0, out_data}, {96'd0, shown});
      chk("out_valid_w", {127'd0, out_valid_w}, {127'd0, q.size() > 0});
      chk("in_ready_w", {127'd0, in_ready_w}, {127'd0, q.size() < 2});
      if (q.size() > 0) chk("out_data_w", {21'd0, out_data_w}, {21'd0, widen(q[0])});
      chk("out_valid_n", {127'd0, out_valid_n}, {127'd0, q.size() > 0});
      chk("in_ready_n", {127'd0, in_ready_n}, {127'd0, q.size() < 2});
      chk("out_data_n", {127'd0, out_data_n}, {127'd0, shown[0]});
`ifdef PIPE_STAGE_STATS_EN
      chk("stall_cnt", {126'd0, stall_cnt}, 128'(m_stall));
      chk("bubble_cnt", {126'd0, bubble_cnt}, 128'(m_bubble));
      chk("stall_w", {126'd0, stall_w}, 128'(m_stall));
      chk("bubble_n", {126'd0, bubble_n}, 128'(m_bubble));
`endif
    end
  end

  initial begin
    shown = '0; m_stall = 0; m_bubble = 0; last_in_fire = 0;
    rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_data = '0;
    step();
    chk_en = 1'b1;
    step();
    rst = 0;
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_out_data", {96'd0, out_data}, 128'd0);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);

    // Single beat, 1-cycle latency.
    in_valid = 1; in_data = 32'h11; out_ready = 1;
    step();
    chk("lat_out_valid", {127'd0, out_valid}, 128'd1);
    chk("lat_out_data", {96'd0, out_data}, 128'h11);
    chk("lat_in_ready", {127'd0, in_ready}, 128'd1);
    in_valid = 0;
    step();

    // Full-rate stream.
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1; in_data = W'(i);
      step();
      chk("stream_data", {96'd0, out_data}, 128'(i));
      chk("stream_ready", {127'd0, in_ready}, 128'd1);
    end
    in_valid = 0;
    step();

    // Back-pressure into the skid register.
    out_ready = 0;
    in_valid = 1; in_data = 32'hA; step();
    chk("bp_first", {96'd0, out_data}, 128'hA);
    in_data = 32'hB; step();
    chk("bp_two_ready", {127'd0, in_ready}, 128'd0);
    in_data = 32'hC; step();
    chk("bp_hold_ready", {127'd0, in_ready}, 128'd0);
    chk("bp_hold_data", {96'd0, out_data}, 128'hA);
    out_ready = 1; step();
    chk("bp_drain_b", {96'd0, out_data}, 128'hB);
    step();
    chk("bp_drain_c", {96'd0, out_data}, 128'hC);
    in_valid = 0; step();

    // Flush while full, with a coincident incoming beat.
    out_ready = 0;
    in_valid = 1; in_data = 32'h21; step();
    in_data = 32'h22; step();
    in_data = 32'hD; flush = 1; step();
    flush = 0; in_valid = 0;
    chk("flush_valid", {127'd0, out_valid}, 128'd0);
    chk("flush_ready", {127'd0, in_ready}, 128'd1);
    chk("flush_data", {96'd0, out_data}, 128'd0);
    out_ready = 1; step(); step();
    chk("flush_no_d", {127'd0, out_valid}, 128'd0);

    // Reset with one entry held.
    out_ready = 0; in_valid = 1; in_data = 32'h33; step();
    in_valid = 0; rst = 1; step();
    rst = 0;
    chk("rst1_valid", {127'd0, out_valid}, 128'd0);
    chk("rst1_data", {96'd0, out_data}, 128'd0);

`ifdef PIPE_STAGE_STATS_EN
    // Stall counter saturation, unaffected by flush.
    out_ready = 0; in_valid = 1; in_data = 32'h44; step();
    in_valid = 0;
    repeat (5) step();
    chk("stall_sat", {126'd0, stall_cnt}, 128'd3);
    flush = 1; step(); flush = 0;
    chk("stall_flush", {126'd0, stall_cnt}, 128'd3);
`endif

    // Randomised traffic with protocol-correct upstream holding.
    out_ready = 1; in_valid = 0; last_in_fire = 0;
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(199) == 0);
      flush     = ($urandom_range(24) == 0);
      out_ready = ($urandom_range(9) < 7);
      if (!in_valid || last_in_fire) begin
        in_valid = ($urandom_range(3) != 0);
        in_data  = $urandom;
      end
      step();
    end
    rst = 0; flush = 0; in_valid = 0;
    step();
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
